// File: rtl/mon_mem_responder.sv
// Monitor-side memory responder: serves level read/write requests on a 1-cycle SRAM port.
// Access 1+WAIT_CYC cycles after acceptance, deferred while mem_busy; write_finish +1, read_valid +2.
module mon_mem_responder #(
  parameter int AWIDTH   = 12,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              u_read_req,
  input  logic              u_read_w,
  input  logic [31:0]       u_read_adr,
  output logic              read_valid,
  output logic [31:0]       read_data,
  input  logic              u_write_req,
  input  logic              u_write_w,
  input  logic [31:0]       u_write_adr,
  input  logic [31:0]       u_write_data,
  output logic              write_finish,
  input  logic              mem_busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [AWIDTH-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              adr_err
);

  typedef enum logic [2:0] {IDLE, WAIT, ACCESS, CAPTURE, DONE} state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        op_wr;
  logic        op_word;
  logic [31:0] op_adr;
  logic [31:0] op_data;
  logic        range_err;
  logic        go;
  logic [7:0]  sel_byte;

  assign range_err = |op_adr[31:AWIDTH+2];
  // The access slot is consumed once the CPU releases the memory, even when the
  // address is out of range, so error and normal handshakes share one timeline.
  assign go        = (state == ACCESS) && !mem_busy;
  assign mem_en    = go && !range_err;
  assign mem_we    = mem_en && op_wr;
  assign mem_be    = mem_en ? (op_word ? 4'hF : (4'b0001 << op_adr[1:0])) : 4'h0;
  assign mem_adr   = mem_en ? op_adr[AWIDTH+1:2] : '0;
  assign mem_wdata = mem_we ? (op_word ? op_data : {4{op_data[7:0]}}) : '0;
  assign adr_err   = go && range_err;

  always_comb begin
    sel_byte = mem_rdata[7:0];
    case (op_adr[1:0])
      2'd0: sel_byte = mem_rdata[7:0];
      2'd1: sel_byte = mem_rdata[15:8];
      2'd2: sel_byte = mem_rdata[23:16];
      2'd3: sel_byte = mem_rdata[31:24];
      default: sel_byte = mem_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= 4'd0;
      op_wr        <= 1'b0;
      op_word      <= 1'b0;
      op_adr       <= 32'd0;
      op_data      <= 32'd0;
      write_finish <= 1'b0;
      read_valid   <= 1'b0;
      read_data    <= 32'd0;
    end else begin
      write_finish <= 1'b0;
      read_valid   <= 1'b0;
      case (state)
        IDLE: begin
          // Write has priority; a concurrent read stays pending on its level.
          if (u_write_req || u_read_req) begin
            op_wr    <= u_write_req;
            op_word  <= u_write_req ? u_write_w : u_read_w;
            op_adr   <= u_write_req ? u_write_adr : u_read_adr;
            op_data  <= u_write_data;
            wait_cnt <= 4'(WAIT_CYC);
            state    <= (WAIT_CYC == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          if (!mem_busy) begin
            if (op_wr) begin
              write_finish <= 1'b1;
              state        <= DONE;
            end else begin
              state <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          read_valid <= 1'b1;
          read_data  <= range_err ? 32'd0 : (op_word ? mem_rdata : {24'd0, sel_byte});
          state      <= DONE;
        end
        DONE: begin
          // Wait for the serviced level to fall so it is never taken twice.
          if (!(op_wr ? u_write_req : u_read_req)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_mem_responder.sv
// Randomized bench for mon_mem_responder against a transaction-level timing/memory model.
module tb_mon_mem_responder;

  localparam int AW   = 12;
  localparam int WC   = 0;
  localparam int NCYC = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        u_read_req = 1'b0, u_read_w = 1'b0, u_write_req = 1'b0, u_write_w = 1'b0;
  logic [31:0] u_read_adr = '0, u_write_adr = '0, u_write_data = '0;
  logic        read_valid, write_finish, mem_en, mem_we, adr_err;
  logic        mem_busy = 1'b0;
  logic [31:0] read_data, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [AW-1:0] mem_adr;

  logic        b_read_req = 1'b0, b_read_w = 1'b0, b_write_req = 1'b0, b_write_w = 1'b0;
  logic [31:0] b_read_adr = '0, b_write_adr = '0, b_write_data = '0;
  logic        b_read_valid, b_write_finish, b_mem_en, b_mem_we, b_adr_err;
  logic        b_mem_busy = 1'b0;
  logic [31:0] b_read_data, b_mem_wdata;
  logic [31:0] b_mem_rdata = 32'hCAFEF00D;
  logic [3:0]  b_mem_be;
  logic [AW-1:0] b_mem_adr;

  mon_mem_responder #(.AWIDTH(AW), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst_n(rst_n),
    .u_read_req(u_read_req), .u_read_w(u_read_w), .u_read_adr(u_read_adr),
    .read_valid(read_valid), .read_data(read_data),
    .u_write_req(u_write_req), .u_write_w(u_write_w), .u_write_adr(u_write_adr),
    .u_write_data(u_write_data), .write_finish(write_finish),
    .mem_busy(mem_busy), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .adr_err(adr_err)
  );

  mon_mem_responder #(.AWIDTH(AW), .WAIT_CYC(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n),
    .u_read_req(b_read_req), .u_read_w(b_read_w), .u_read_adr(b_read_adr),
    .read_valid(b_read_valid), .read_data(b_read_data),
    .u_write_req(b_write_req), .u_write_w(b_write_w), .u_write_adr(b_write_adr),
    .u_write_data(b_write_data), .write_finish(b_write_finish),
    .mem_busy(b_mem_busy), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be),
    .mem_adr(b_mem_adr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .adr_err(b_adr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] sram    [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h0100_0193) ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // SRAM seen by the main instance: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_adr] <= merge(sram[mem_adr], mem_wdata, mem_be);
      else        mem_rdata <= sram[mem_adr];
    end
  end

  // Expected per-cycle schedule produced by the transaction model.
  bit          exp_en [NCYC];
  bit          exp_we [NCYC];
  bit          exp_err[NCYC];
  bit          exp_wf [NCYC];
  bit          exp_rv [NCYC];
  logic [3:0]  exp_be [NCYC];
  logic [AW-1:0] exp_adr[NCYC];
  logic [31:0] exp_wd [NCYC];
  logic [31:0] exp_rdv[NCYC];
  bit          busy_sched[NCYC];

  int          checks = 0, failures = 0;
  bit          chk_on = 1'b0;
  logic [31:0] cur_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < NCYC) begin
      check("mem_en", 32'(mem_en), 32'(exp_en[cyc]));
      if (exp_en[cyc]) begin
        check("mem_we", 32'(mem_we), 32'(exp_we[cyc]));
        check("mem_be", 32'(mem_be), 32'(exp_be[cyc]));
        check("mem_adr", 32'(mem_adr), 32'(exp_adr[cyc]));
        if (exp_we[cyc]) check("mem_wdata", mem_wdata, exp_wd[cyc]);
      end
      check("adr_err", 32'(adr_err), 32'(exp_err[cyc]));
      check("write_finish", 32'(write_finish), 32'(exp_wf[cyc]));
      check("read_valid", 32'(read_valid), 32'(exp_rv[cyc]));
      if (exp_rv[cyc]) cur_rd = exp_rdv[cyc];
      check("read_data", read_data, cur_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    mem_busy = (cyc < NCYC) ? busy_sched[cyc] : 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Request accepted at cycle c0: access at the first non-busy cycle after the wait
  // states, completion one (write) or two (read) cycles later.
  task automatic predict(input bit wr, input bit w, input logic [31:0] adr,
                         input logic [31:0] dat, input int c0, output int a, output int d);
    bit          err;
    logic [3:0]  be;
    logic [31:0] wd, word;
    int          idx;
    err = (adr[31:AW+2] != 0);
    idx = int'(adr[AW+1:2]);
    be  = w ? 4'hF : (4'b0001 << adr[1:0]);
    wd  = w ? dat : {4{dat[7:0]}};
    a   = c0 + 1 + WC;
    while (a < NCYC - 4 && busy_sched[a]) a++;
    if (a >= NCYC - 4) begin
      checks++;
      failures++;
      $display("FAIL model_bound cyc=%0d got=%0d expected<%0d", cyc, a, NCYC - 4);
      a = NCYC - 4;
    end
    if (err) exp_err[a] = 1'b1;
    else begin
      exp_en[a] = 1'b1; exp_we[a] = wr; exp_be[a] = be;
      exp_adr[a] = adr[AW+1:2]; exp_wd[a] = wd;
    end
    if (wr) begin
      d = a + 1;
      exp_wf[d] = 1'b1;
      if (!err) ref_mem[idx] = merge(ref_mem[idx], wd, be);
    end else begin
      d = a + 2;
      word = err ? 32'd0 : ref_mem[idx];
      exp_rv[d]  = 1'b1;
      exp_rdv[d] = w ? word : {24'd0, word[8*adr[1:0] +: 8]};
    end
  endtask

  // hold > 0: request high for exactly hold cycles; hold == 0: dropped after
  // completion; hold < 0: dropped at a random point before completion.
  task automatic run_txn(input bit wr, input bit w, input logic [31:0] adr,
                         input logic [31:0] dat, input int hold, output int a, output int d);
    int c0, p, last;
    c0 = cyc;
    if (wr) begin
      u_write_req = 1'b1; u_write_w = w; u_write_adr = adr; u_write_data = dat;
    end else begin
      u_read_req = 1'b1; u_read_w = w; u_read_adr = adr;
    end
    predict(wr, w, adr, dat, c0, a, d);
    if (hold > 0)      p = c0 + hold;
    else if (hold < 0) p = c0 + 1 + int'($urandom_range(0, 32'(d - c0 - 1)));
    else               p = d + 1 + int'($urandom_range(0, 2));
    last = ((d > p) ? d : p) + 1;
    while (cyc < last) begin
      step();
      if (cyc == p) begin
        u_write_req = 1'b0; u_read_req = 1'b0;
        u_write_adr = $urandom; u_write_data = $urandom; u_read_adr = $urandom;
        u_write_w = 1'($urandom); u_read_w = 1'($urandom);
      end
    end
  endtask

  int c0, a, d, f_en, f_rv, n_en, n_rv;
  logic [31:0] rv_dat, radr;
  bit rwr, rw;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    step(); step();
    @(negedge clk);
    check("rst_ctl", 32'({mem_en, mem_we, mem_be, mem_adr, adr_err, write_finish, read_valid}), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_b", 32'({b_mem_en, b_read_valid, b_write_finish, b_adr_err}), 32'd0);
    step();
    rst_n = 1'b1;
    chk_on = 1'b1;
    step();

    c0 = cyc;
    run_txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 0, a, d);
    check("lat_wr_en", 32'(a - c0), 32'd1);
    check("lat_wr_fin", 32'(d - c0), 32'd2);
    check("pin_be_word", 32'(exp_be[a]), 32'hF);
    check("pin_adr_word", 32'(exp_adr[a]), 32'd4);

    c0 = cyc;
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 0, a, d);
    check("lat_rd", 32'(d - c0), 32'd3);
    check("word_rd", read_data, 32'hDEADBEEF);

    run_txn(1'b1, 1'b0, 32'h13, 32'h1234565A, 0, a, d);
    check("pin_be_byte", 32'(exp_be[a]), 32'h8);
    check("pin_wd_byte", exp_wd[a], 32'h5A5A5A5A);
    run_txn(1'b0, 1'b0, 32'h13, 32'h0, 0, a, d);
    check("byte_rd", read_data, 32'h0000005A);
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 0, a, d);
    check("merged_rd", read_data, 32'h5AADBEEF);

    c0 = cyc;
    u_write_req = 1'b1; u_write_w = 1'b1; u_write_adr = 32'h20; u_write_data = 32'h0BADF00D;
    u_read_req = 1'b1; u_read_w = 1'b1; u_read_adr = 32'h20;
    predict(1'b1, 1'b1, 32'h20, 32'h0BADF00D, c0, a, d);
    wait_until(d + 1);
    u_write_req = 1'b0;
    wait_until(d + 2);
    predict(1'b0, 1'b1, 32'h20, 32'h0, cyc, a, d);
    wait_until(d + 1);
    u_read_req = 1'b0;
    wait_until(d + 2);
    check("simul_rd", read_data, 32'h0BADF00D);

    run_txn(1'b0, 1'b1, 32'h0001_0000, 32'h0, 0, a, d);
    check("pin_err", 32'(exp_err[a]), 32'd1);
    check("oor_rd", read_data, 32'd0);
    run_txn(1'b1, 1'b1, 32'h0001_0000, 32'hFFFFFFFF, 0, a, d);
    run_txn(1'b0, 1'b1, 32'h0, 32'h0, 0, a, d);
    check("oor_wr_dropped", read_data, init_val(0));

    run_txn(1'b0, 1'b1, 32'h20, 32'h0, 20, a, d);
    run_txn(1'b0, 1'b0, 32'h11, 32'h0, 1, a, d);
    check("early_drop_rd", read_data, 32'h000000BE);

    c0 = cyc;
    b_read_req = 1'b1; b_read_w = 1'b1; b_read_adr = 32'h40;
    f_en = -1; f_rv = -1; n_en = 0; n_rv = 0; rv_dat = '0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      b_mem_busy = (k >= 4 && k <= 8);
      @(negedge clk);
      if (b_mem_en) begin n_en++; if (f_en < 0) f_en = k; end
      if (b_read_valid) begin
        n_rv++;
        if (f_rv < 0) begin f_rv = k; rv_dat = b_read_data; end
        b_read_req = 1'b0;
      end
    end
    check("w3_en_cycle", 32'(f_en), 32'd9);
    check("w3_en_count", 32'(n_en), 32'd1);
    check("w3_rv_cycle", 32'(f_rv), 32'd11);
    check("w3_rv_count", 32'(n_rv), 32'd1);
    check("w3_rdata", rv_dat, 32'hCAFEF00D);
    step();

    chk_on = 1'b0;
    u_read_req = 1'b1; u_read_w = 1'b1; u_read_adr = 32'h10;
    step();
    check("abort_pre_en", 32'(mem_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ctl", 32'({mem_en, mem_we, mem_be, mem_adr, adr_err, write_finish, read_valid}), 32'd0);
    check("abort_wdata", mem_wdata, 32'd0);
    check("abort_rdata", read_data, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = cyc; i < NCYC; i++) begin
      exp_en[i] = 0; exp_we[i] = 0; exp_err[i] = 0; exp_wf[i] = 0; exp_rv[i] = 0;
    end
    cur_rd = '0;
    chk_on = 1'b1;
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 0, a, d);
    check("after_reset_rd", read_data, 32'h5AADBEEF);

    for (int i = cyc + 1; i < NCYC; i++) busy_sched[i] = ($urandom_range(0, 3) == 0);
    for (int t = 0; t < 150; t++) begin
      rwr = 1'($urandom);
      rw  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        radr = $urandom;
        if (radr[31:AW+2] == 0) radr[31] = 1'b1;
      end else begin
        radr = $urandom_range(0, 63);
      end
      run_txn(rwr, rw, radr, $urandom, ($urandom_range(0, 5) == 0) ? -1 : 0, a, d);
      repeat ($urandom_range(0, 2)) step();
    end
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
